// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - run sequencer that paces an external enable-counter up to a terminal count
//
// Ports:
//   clk    system clock, rising edge
//   r      asynchronous active-high reset
//   start  begin a run (accepted only in IDLE, and only when abort is low)
//   pause  hold run progress while high
//   abort  cancel the current run, no completion pulse
//   limit  terminal count, captured while in CLEAR
//   q      present value of the external counter
//   ec     count-enable pulse to the counter, one every DIV run cycles
//   clr    synchronous clear to the counter (CLEAR state)
//   busy   high in CLEAR, RUN and PAUSE
//   done   one-cycle completion pulse (DONE state)
//   state  current state code: IDLE=0 CLEAR=1 RUN=2 PAUSE=3 DONE=4
module count_sequencer #(
    parameter int DIV = 4,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         r,
    input  logic         start,
    input  logic         pause,
    input  logic         abort,
    input  logic [W-1:0] limit,
    input  logic [W-1:0] q,
    output logic         ec,
    output logic         clr,
    output logic         busy,
    output logic         done,
    output logic [2:0]   state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // DIV is at least 2, so this is never narrower than one bit.
    localparam int            PW       = $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [2:0]    state_r;
    logic [2:0]    state_nx;
    logic [PW-1:0] pre_r;
    logic [W-1:0]  lim_r;
    logic          term;

    assign term  = (q == lim_r);
    assign state = state_r;

    // State register.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic. Abort outranks everything; terminal count outranks pause.
    always_comb begin
        state_nx = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (start && !abort) state_nx = S_CLEAR;
                else                 state_nx = S_IDLE;
            end
            S_CLEAR: begin
                if (abort) state_nx = S_IDLE;
                else       state_nx = S_RUN;
            end
            S_RUN: begin
                if (abort)      state_nx = S_IDLE;
                else if (term)  state_nx = S_DONE;
                else if (pause) state_nx = S_PAUSE;
                else            state_nx = S_RUN;
            end
            S_PAUSE: begin
                if (abort)      state_nx = S_IDLE;
                else if (pause) state_nx = S_PAUSE;
                else            state_nx = S_RUN;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Prescaler advances on every RUN cycle (including the one in which pause
    // is first seen) and freezes in PAUSE, so a pause of N cycles stretches
    // the ec spacing by exactly N.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            pre_r <= '0;
        end else if (state_r == S_CLEAR) begin
            pre_r <= '0;
        end else if (state_r == S_RUN) begin
            if (pre_r == PRE_LAST) pre_r <= '0;
            else                   pre_r <= pre_r + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            lim_r <= '0;
        end else if (state_r == S_CLEAR) begin
            lim_r <= limit;
        end
    end

    // Outputs decode registered state; only ec also looks at q.
    always_comb begin
        ec   = (state_r == S_RUN) && (pre_r == PRE_LAST) && !term;
        clr  = (state_r == S_CLEAR);
        busy = (state_r == S_CLEAR) || (state_r == S_RUN) || (state_r == S_PAUSE);
        done = (state_r == S_DONE);
    end

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - directed vector bench for count_sequencer
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] limit = 4'd0;
    logic [3:0] q_m;
    logic       ec, clr, busy, done;
    logic [2:0] state;

    count_sequencer #(.DIV(4), .W(4)) dut (
        .clk(clk), .r(r), .start(start), .pause(pause), .abort(abort),
        .limit(limit), .q(q_m), .ec(ec), .clr(clr), .busy(busy),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // Enable-counter model driven by the sequencer.
    always @(posedge clk or posedge r) begin
        if (r)        q_m <= 4'd0;
        else if (clr) q_m <= 4'd0;
        else if (ec)  q_m <= q_m + 4'd1;
    end

    int cyc = 0;
    int ec_count = 0;
    int done_count = 0;
    int ec_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ec) begin
            ec_count = ec_count + 1;
            ec_cyc.push_back(cyc);
        end
        if (done) done_count = done_count + 1;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_ec(input int target, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (ec_count >= target) break;
        end
        check({name, "_ec_reached"}, int'(ec_count >= target), 1);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_count >= target) break;
        end
        check({name, "_done_reached"}, int'(done_count >= target), 1);
    endtask

    task automatic pulse_start(input logic [3:0] lim);
        @(posedge clk); #1;
        start = 1'b1;
        limit = lim;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    typedef struct {
        logic       start, pause, abort;
        logic [3:0] limit;
        logic [2:0] st;
        logic       ec, clr, busy, done;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic s, input logic p, input logic a, input logic [3:0] l,
                                input logic [2:0] st, input logic e, input logic c,
                                input logic b, input logic d);
        vec_t v;
        v.start = s; v.pause = p; v.abort = a; v.limit = l;
        v.st = st; v.ec = e; v.clr = c; v.busy = b; v.done = d;
        return v;
    endfunction

    initial begin
        int base;
        int dbase;
        int gap;

        //            st p  a  lim   state ec clr busy done
        tbl[0]  = mk(1, 0, 0, 4'd3, 3'd0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 4'd3, 3'd1, 0, 1, 1, 0);
        tbl[2]  = mk(0, 0, 0, 4'd3, 3'd2, 0, 0, 1, 0);
        tbl[3]  = mk(1, 0, 0, 4'd9, 3'd2, 0, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 4'd9, 3'd2, 0, 0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 4'd9, 3'd2, 1, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 4'd9, 3'd2, 0, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 4'd9, 3'd2, 0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 4'd9, 3'd2, 0, 0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 4'd9, 3'd2, 1, 0, 1, 0);
        tbl[10] = mk(0, 0, 0, 4'd9, 3'd2, 0, 0, 1, 0);
        tbl[11] = mk(0, 0, 0, 4'd9, 3'd2, 0, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 4'd9, 3'd2, 0, 0, 1, 0);
        tbl[13] = mk(0, 0, 0, 4'd9, 3'd2, 1, 0, 1, 0);
        tbl[14] = mk(0, 0, 0, 4'd9, 3'd2, 0, 0, 1, 0);
        tbl[15] = mk(0, 0, 0, 4'd9, 3'd4, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 4'd9, 3'd0, 0, 0, 0, 0);
        tbl[17] = mk(1, 0, 0, 4'd0, 3'd0, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 4'd0, 3'd1, 0, 1, 1, 0);
        tbl[19] = mk(0, 1, 0, 4'd0, 3'd2, 0, 0, 1, 0);
        tbl[20] = mk(1, 0, 0, 4'd0, 3'd4, 0, 0, 0, 1);
        tbl[21] = mk(1, 0, 1, 4'd0, 3'd0, 0, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 4'd0, 3'd0, 0, 0, 0, 0);
        tbl[23] = mk(0, 0, 0, 4'd0, 3'd0, 0, 0, 0, 0);

        // Reset state, checked before any clock edge.
        #1;
        check("rst_state", int'(state), 0);
        check("rst_ec",    int'(ec),    0);
        check("rst_clr",   int'(clr),   0);
        check("rst_busy",  int'(busy),  0);
        check("rst_done",  int'(done),  0);
        @(posedge clk); @(posedge clk); #1;
        r = 1'b0;

        // Vector table: basic limit=3 run, limit=0 run, ignored starts, start+abort.
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            start = tbl[i].start;
            pause = tbl[i].pause;
            abort = tbl[i].abort;
            limit = tbl[i].limit;
            @(negedge clk);
            check($sformatf("vec%0d_state", i), int'(state), int'(tbl[i].st));
            check($sformatf("vec%0d_ec",    i), int'(ec),    int'(tbl[i].ec));
            check($sformatf("vec%0d_clr",   i), int'(clr),   int'(tbl[i].clr));
            check($sformatf("vec%0d_busy",  i), int'(busy),  int'(tbl[i].busy));
            check($sformatf("vec%0d_done",  i), int'(done),  int'(tbl[i].done));
        end
        @(posedge clk); #1;
        start = 1'b0; pause = 1'b0; abort = 1'b0;

        // Pause of 10 cycles between the 2nd and 3rd pulse of a limit=5 run.
        base  = ec_count;
        dbase = done_count;
        pulse_start(4'd5);
        wait_ec(base + 2, 40, "pause");
        @(posedge clk); #1;
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 9) pause = 1'b0;
            @(negedge clk);
            check($sformatf("pause%0d_state", i), int'(state), 3);
            check($sformatf("pause%0d_ec", i), int'(ec), 0);
        end
        wait_ec(base + 3, 40, "pause3");
        gap = ec_cyc[ec_cyc.size()-1] - ec_cyc[ec_cyc.size()-2];
        check("pause_gap", gap, 14);
        wait_done(dbase + 1, 60, "pause");
        check("pause_total_ec", ec_count - base, 5);

        // Abort mid-run after two pulses.
        base  = ec_count;
        dbase = done_count;
        pulse_start(4'd6);
        wait_ec(base + 2, 40, "abort");
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_pre_state", int'(state), 2);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_state", int'(state), 0);
        check("abort_ec", int'(ec), 0);
        check("abort_busy", int'(busy), 0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", done_count - dbase, 0);
        check("abort_no_more_ec", ec_count - base, 2);
        base = ec_count;
        pulse_start(4'd2);
        wait_done(dbase + 1, 40, "after_abort");
        check("after_abort_ec", ec_count - base, 2);

        // Asynchronous reset between edges mid-run, then a full-range run.
        base  = ec_count;
        dbase = done_count;
        pulse_start(4'd15);
        wait_ec(base + 1, 40, "rst_run");
        @(posedge clk); #2;
        r = 1'b1;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_ec",    int'(ec),    0);
        check("async_rst_clr",   int'(clr),   0);
        check("async_rst_busy",  int'(busy),  0);
        check("async_rst_done",  int'(done),  0);
        @(posedge clk); #1;
        r = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_done", done_count - dbase, 0);
        base = ec_count;
        pulse_start(4'd15);
        wait_ec(base + 3, 40, "full");
        pulse_start(4'd1);
        @(negedge clk);
        check("busy_start_ignored", int'(state), 2);
        wait_done(dbase + 1, 100, "full");
        check("full_ec_count", ec_count - base, 15);
        @(negedge clk);
        check("full_idle_busy", int'(busy), 0);

        // Pause raised in the same cycle q reaches the limit.
        base  = ec_count;
        dbase = done_count;
        pulse_start(4'd1);
        wait_ec(base + 1, 40, "term_pause");
        @(posedge clk); #1;
        pause = 1'b1;
        @(negedge clk);
        check("term_pause_run", int'(state), 2);
        check("term_pause_ec", int'(ec), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("term_pause_state", int'(state), 4);
        check("term_pause_done", int'(done), 1);
        pause = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("term_pause_idle", int'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter DIV, default 4, sets the ec pulse period in clk cycles (legal range 2..16).
REQ-002 Parameter W, default 4, sets the width of limit and q.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 r  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level-sampled request to begin a counting run.
REQ-006 pause  input  1  hold request; freezes run progress while high.
REQ-007 abort  input  1  cancels the current run.
REQ-008 limit  input  W  terminal count for the run; sampled into an internal register in CLEAR.
REQ-009 q  input  W  present value of the controlled enable-counter.
REQ-010 ec  output  1  count-enable to the counter; one-cycle pulses.
REQ-011 clr  output  1  synchronous clear to the counter.
REQ-012 busy  output  1  high in CLEAR, RUN and PAUSE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 state  output  3  current FSM state code.

Function
REQ-015 The FSM SHALL have five states, encoded IDLE=0, CLEAR=1, RUN=2, PAUSE=3, DONE=4; codes 5-7 go to IDLE on the next edge.
REQ-016 The FSM SHALL go from IDLE to CLEAR when start=1 and abort=0.
REQ-017 CLEAR SHALL last exactly one cycle with clr=1, latch limit into lim_r, zero the prescaler, then go to RUN.
REQ-018 In RUN the W-bit-clean prescaler SHALL count 0..DIV-1 and wrap to 0.
REQ-019 ec SHALL be 1 only when state=RUN, prescaler=DIV-1 and q!=lim_r, so pulses are spaced exactly DIV cycles apart.
REQ-020 In RUN, q==lim_r SHALL move the FSM to DONE on the next edge and suppress ec that cycle; lim_r=0 gives zero ec pulses.
REQ-021 In RUN, pause=1 with q!=lim_r SHALL move the FSM to PAUSE; the prescaler holds its value and ec=0.
REQ-022 In PAUSE, pause=0 SHALL return the FSM to RUN, with the prescaler resuming from the held value.
REQ-023 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-024 abort=1 in CLEAR, RUN or PAUSE SHALL force IDLE on the next edge with done=0; abort has priority over all other inputs.
REQ-025 start SHALL be ignored in every state except IDLE; start=1 while in DONE does not retrigger until IDLE is reached.
REQ-026 Terminal detect SHALL take priority over pause in the same cycle.
REQ-027 Comparison of q with lim_r SHALL be full-width equality; a limit of 2^W-1 is legal and needs no wrap handling.
REQ-028 ec, clr, done and busy SHALL be decoded from registered state only (Moore), with no input-to-output combinational path except the q term in ec.

Reset
REQ-029 r=1 SHALL immediately, without a clock edge, set state=IDLE, prescaler=0, lim_r=0, ec=0, clr=0, busy=0 and done=0.
REQ-030 Deassertion of r SHALL take effect at the first rising clk edge after it; an r pulse mid-run discards the run with no done pulse.

Verification
REQ-031 The bench SHALL cover: DIV=4, limit=3, one-cycle start pulse, counter model incrementing on ec -> clr=1 for 1 cycle; exactly 3 ec pulses 4 cycles apart; done=1 for 1 cycle in the cycle after q reaches 3; busy low afterwards.
REQ-032 The bench SHALL cover: limit=0, start -> CLEAR, then RUN for 1 cycle, then DONE; zero ec pulses; done pulse 3 cycles after start is sampled.
REQ-033 The bench SHALL cover: limit=5, pause held for 10 cycles between the 2nd and 3rd ec -> gap between those pulses is 14 cycles; no ec during PAUSE; state=3 throughout.
REQ-034 The bench SHALL cover: abort during RUN after 2 pulses -> state=0 next edge; done never asserts; ec=0; a later start runs normally.
REQ-035 The bench SHALL cover: r asserted asynchronously mid-RUN between clock edges -> all outputs 0 before the next edge; after release and start with limit=15 -> exactly 15 ec pulses, and a start during busy is ignored.
REQ-036 The bench SHALL cover: pause=1 in the cycle q==lim_r -> DONE is taken, not PAUSE; start and abort high together in IDLE -> FSM stays in IDLE.
